// File: rtl/yags_dir_cache_pkg.sv
// Shared types for the YAGS tagged direction cache: counter encoding, entry layout and training helper.
package yags_dir_cache_pkg;

  localparam int unsigned TAG_BITS_DEF = 4;
  localparam int unsigned WAYS_DEF     = 2;
  localparam int unsigned AGE_BITS_DEF = (WAYS_DEF > 1) ? $clog2(WAYS_DEF) : 1;

  typedef enum logic [1:0] {
    strongly_not_taken = 2'd0,
    weakly_not_taken   = 2'd1,
    weakly_taken       = 2'd2,
    strongly_taken     = 2'd3
  } counter_states;

  typedef struct packed {
    logic                    valid;
    logic [TAG_BITS_DEF-1:0] tag;
    counter_states           ctr;
    logic [AGE_BITS_DEF-1:0] age;
  } yags_entry_t;

  // Saturating step of a 2-bit counter toward the resolved outcome.
  function automatic counter_states ctr_train(input counter_states c, input logic taken);
    counter_states r;
    r = c;
    if (taken && (c != strongly_taken)) begin
      r = counter_states'(2'(c + 2'd1));
    end else if (!taken && (c != strongly_not_taken)) begin
      r = counter_states'(2'(c - 2'd1));
    end
    return r;
  endfunction

endpackage

// File: rtl/yags_lru_rank.sv
// True-LRU age ranking for one set: MRU promotion of an accessed way and victim selection.
module yags_lru_rank #(
  parameter int unsigned WAYS = 2,
  parameter int unsigned AW   = 1
) (
  input  logic [WAYS-1:0]         valid_i,
  input  logic [WAYS-1:0][AW-1:0] ages_i,
  input  logic [AW-1:0]           acc_way_i,
  output logic [WAYS-1:0][AW-1:0] ages_o,
  output logic [AW-1:0]           victim_o
);

  logic found_c;

  // Accessed way goes to age 0; ways younger than it age by one.
  always_comb begin
    ages_o = ages_i;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (AW'(w) == acc_way_i) begin
        ages_o[w] = '0;
      end else if (ages_i[w] < ages_i[acc_way_i]) begin
        ages_o[w] = ages_i[w] + AW'(1);
      end
    end
  end

  // Lowest invalid way first, otherwise the oldest way.
  always_comb begin
    victim_o = '0;
    found_c  = 1'b0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (!found_c && !valid_i[w]) begin
        victim_o = AW'(w);
        found_c  = 1'b1;
      end
    end
    if (!found_c) begin
      for (int w = 0; w < int'(WAYS); w++) begin
        if (ages_i[w] == AW'(WAYS - 1)) begin
          victim_o = AW'(w);
        end
      end
    end
  end

endmodule

// File: rtl/yags_dir_cache.sv
// N-way tagged YAGS direction cache with registered lookup and single-cycle training update.
// Optional statistics counters are compiled in when YAGS_DIR_STATS_EN is defined.
module yags_dir_cache
  import yags_dir_cache_pkg::*;
#(
  parameter int unsigned WAYS     = 2,
  parameter int unsigned SETS     = 32,
  parameter int unsigned TAG_BITS = 4,
  parameter int unsigned PC_SIZE  = 10,
  parameter int unsigned GHR_SIZE = 10
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        flush,
  input  logic                                        rd_valid,
  input  logic [PC_SIZE-1:0]                          rd_pc,
  input  logic [GHR_SIZE-1:0]                         rd_ghr,
  output logic                                        rd_resp_valid,
  output logic                                        rd_hit,
  output logic                                        rd_taken,
  output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0]  rd_way,
  input  logic                                        upd_valid,
  input  logic [PC_SIZE-1:0]                          upd_pc,
  input  logic [GHR_SIZE-1:0]                         upd_ghr,
  input  logic                                        upd_taken,
  input  logic                                        upd_choice_taken,
  output logic [31:0]                                 stat_lookups,
  output logic [31:0]                                 stat_hits,
  output logic [31:0]                                 stat_allocs
);

  localparam int unsigned IDX = $clog2(SETS);
  localparam int unsigned AW  = (WAYS > 1) ? $clog2(WAYS) : 1;

  function automatic logic [IDX-1:0] set_of(input logic [PC_SIZE-1:0] pc,
                                            input logic [GHR_SIZE-1:0] ghr);
    return pc[IDX+1:2] ^ ghr[IDX-1:0];
  endfunction

  function automatic logic [TAG_BITS-1:0] tag_of(input logic [PC_SIZE-1:0] pc);
    return pc[TAG_BITS+1:2];
  endfunction

  function automatic logic [WAYS-1:0][AW-1:0] age_init();
    logic [WAYS-1:0][AW-1:0] r;
    for (int w = 0; w < int'(WAYS); w++) begin
      r[w] = AW'(w);
    end
    return r;
  endfunction

  logic [WAYS-1:0]          valid_q [SETS];
  logic [WAYS-1:0]          valid_d [SETS];
  logic [TAG_BITS-1:0]      tag_q   [SETS][WAYS];
  logic [TAG_BITS-1:0]      tag_d   [SETS][WAYS];
  counter_states            ctr_q   [SETS][WAYS];
  counter_states            ctr_d   [SETS][WAYS];
  logic [WAYS-1:0][AW-1:0]  age_q   [SETS];
  logic [WAYS-1:0][AW-1:0]  age_d   [SETS];

  logic          rd_resp_valid_q, rd_resp_valid_d;
  logic          rd_hit_q, rd_hit_d;
  logic          rd_taken_q, rd_taken_d;
  logic [AW-1:0] rd_way_q, rd_way_d;

  logic [IDX-1:0]          rd_set_c, upd_set_c;
  logic [TAG_BITS-1:0]     rd_tag_c, upd_tag_c;
  logic                    rd_hit_c, upd_hit_c, rd_taken_c, alloc_c;
  logic [AW-1:0]           rd_way_c, upd_way_c, victim_c, acc_way_c;
  logic [WAYS-1:0][AW-1:0] upd_ages_c;

  // Tag match on the lookup port; descending scan so the lowest way wins.
  always_comb begin
    rd_set_c = set_of(rd_pc, rd_ghr);
    rd_tag_c = tag_of(rd_pc);
    rd_hit_c = 1'b0;
    rd_way_c = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (valid_q[rd_set_c][w] && (tag_q[rd_set_c][w] == rd_tag_c)) begin
        rd_hit_c = 1'b1;
        rd_way_c = AW'(w);
      end
    end
    rd_taken_c = rd_hit_c & ctr_q[rd_set_c][rd_way_c][1];
  end

  always_comb begin
    upd_set_c = set_of(upd_pc, upd_ghr);
    upd_tag_c = tag_of(upd_pc);
    upd_hit_c = 1'b0;
    upd_way_c = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (valid_q[upd_set_c][w] && (tag_q[upd_set_c][w] == upd_tag_c)) begin
        upd_hit_c = 1'b1;
        upd_way_c = AW'(w);
      end
    end
  end

  assign acc_way_c = upd_hit_c ? upd_way_c : victim_c;

  yags_lru_rank #(
    .WAYS (WAYS),
    .AW   (AW)
  ) u_lru (
    .valid_i   (valid_q[upd_set_c]),
    .ages_i    (age_q[upd_set_c]),
    .acc_way_i (acc_way_c),
    .ages_o    (upd_ages_c),
    .victim_o  (victim_c)
  );

  // Flush wins over a same-cycle training request.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    ctr_d   = ctr_q;
    age_d   = age_q;
    alloc_c = 1'b0;
    if (flush) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_d[s] = '0;
        age_d[s]   = age_init();
      end
    end else if (upd_valid) begin
      if (upd_hit_c) begin
        ctr_d[upd_set_c][upd_way_c] = ctr_train(ctr_q[upd_set_c][upd_way_c], upd_taken);
        age_d[upd_set_c]            = upd_ages_c;
      end else if (upd_taken != upd_choice_taken) begin
        alloc_c                               = 1'b1;
        valid_d[upd_set_c][victim_c]          = 1'b1;
        tag_d[upd_set_c][victim_c]            = upd_tag_c;
        ctr_d[upd_set_c][victim_c]            = upd_taken ? weakly_taken : weakly_not_taken;
        age_d[upd_set_c]                      = upd_ages_c;
      end
    end
  end

  always_comb begin
    rd_resp_valid_d = rd_valid;
    rd_hit_d        = rd_hit_q;
    rd_taken_d      = rd_taken_q;
    rd_way_d        = rd_way_q;
    if (rd_valid) begin
      rd_hit_d   = rd_hit_c & ~flush;
      rd_taken_d = rd_taken_c & ~flush;
      rd_way_d   = flush ? '0 : rd_way_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        age_q[s]   <= age_init();
        for (int w = 0; w < int'(WAYS); w++) begin
          tag_q[s][w] <= '0;
          ctr_q[s][w] <= strongly_not_taken;
        end
      end
      rd_resp_valid_q <= 1'b0;
      rd_hit_q        <= 1'b0;
      rd_taken_q      <= 1'b0;
      rd_way_q        <= '0;
    end else begin
      valid_q         <= valid_d;
      tag_q           <= tag_d;
      ctr_q           <= ctr_d;
      age_q           <= age_d;
      rd_resp_valid_q <= rd_resp_valid_d;
      rd_hit_q        <= rd_hit_d;
      rd_taken_q      <= rd_taken_d;
      rd_way_q        <= rd_way_d;
    end
  end

  assign rd_resp_valid = rd_resp_valid_q;
  assign rd_hit        = rd_hit_q;
  assign rd_taken      = rd_taken_q;
  assign rd_way        = rd_way_q;

`ifdef YAGS_DIR_STATS_EN
  logic [31:0] lookups_q, lookups_d;
  logic [31:0] hits_q, hits_d;
  logic [31:0] allocs_q, allocs_d;

  // Saturating event counters; flush leaves them alone.
  always_comb begin
    lookups_d = lookups_q;
    hits_d    = hits_q;
    allocs_d  = allocs_q;
    if (rd_valid && (lookups_q != 32'hFFFF_FFFF)) lookups_d = lookups_q + 32'd1;
    if (rd_valid && rd_hit_d && (hits_q != 32'hFFFF_FFFF)) hits_d = hits_q + 32'd1;
    if (alloc_c && (allocs_q != 32'hFFFF_FFFF)) allocs_d = allocs_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lookups_q <= '0;
      hits_q    <= '0;
      allocs_q  <= '0;
    end else begin
      lookups_q <= lookups_d;
      hits_q    <= hits_d;
      allocs_q  <= allocs_d;
    end
  end

  assign stat_lookups = lookups_q;
  assign stat_hits    = hits_q;
  assign stat_allocs  = allocs_q;
`else
  assign stat_lookups = 32'd0;
  assign stat_hits    = 32'd0;
  assign stat_allocs  = 32'd0;
`endif

  logic unused_ok;
  assign unused_ok = ^{rd_pc, rd_ghr, upd_pc, upd_ghr, alloc_c};

endmodule

// File: tb/tb_yags_dir_cache.sv
// Self-checking bench for yags_dir_cache: directed scenarios plus randomized traffic against a recency-stamp model.
module tb_yags_dir_cache;
  import yags_dir_cache_pkg::*;

  localparam int NSETS = 32;
  localparam int NWAYS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        rd_valid = 1'b0;
  logic [9:0]  rd_pc = '0;
  logic [9:0]  rd_ghr = '0;
  logic        rd_resp_valid, rd_hit, rd_taken;
  logic [0:0]  rd_way;
  logic        upd_valid = 1'b0;
  logic [9:0]  upd_pc = '0;
  logic [9:0]  upd_ghr = '0;
  logic        upd_taken = 1'b0;
  logic        upd_choice_taken = 1'b0;
  logic [31:0] stat_lookups, stat_hits, stat_allocs;

  yags_dir_cache dut (
    .clk(clk), .reset(reset), .flush(flush),
    .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_ghr(rd_ghr),
    .rd_resp_valid(rd_resp_valid), .rd_hit(rd_hit), .rd_taken(rd_taken), .rd_way(rd_way),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
    .upd_taken(upd_taken), .upd_choice_taken(upd_choice_taken),
    .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_allocs(stat_allocs)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: per-way entry plus a last-touch stamp; the LRU way has the smallest stamp.
  yags_entry_t m_ent   [NSETS][NWAYS];
  int          m_stamp [NSETS][NWAYS];
  int          m_now;
  bit [31:0]   m_lookups, m_hits, m_allocs;
  bit          exp_valid, exp_hit, exp_taken;
  int          exp_way;

  function automatic bit [31:0] st(input bit [31:0] v);
`ifdef YAGS_DIR_STATS_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  function automatic int m_set(input int pc, input int ghr);
    return ((pc >> 2) ^ ghr) & (NSETS - 1);
  endfunction

  function automatic int m_tagv(input int pc);
    return (pc >> 2) & 15;
  endfunction

  task automatic m_clear();
    for (int s = 0; s < NSETS; s++)
      for (int w = 0; w < NWAYS; w++) begin
        m_ent[s][w].valid = 1'b0;
        m_stamp[s][w] = -w;
      end
    m_now = 0;
  endtask

  task automatic m_reset();
    m_clear();
    m_lookups = 0; m_hits = 0; m_allocs = 0;
    exp_valid = 0; exp_hit = 0; exp_taken = 0; exp_way = 0;
  endtask

  task automatic m_find(input int pc, input int ghr, output bit hit, output int way);
    int s;
    s = m_set(pc, ghr);
    hit = 0; way = 0;
    for (int w = NWAYS - 1; w >= 0; w--)
      if (m_ent[s][w].valid && int'(m_ent[s][w].tag) == m_tagv(pc)) begin
        hit = 1; way = w;
      end
  endtask

  task automatic m_update(input int pc, input int ghr, input bit t, input bit c);
    int s, w, v, c2;
    bit hit;
    s = m_set(pc, ghr);
    m_find(pc, ghr, hit, w);
    if (hit) begin
      c2 = int'(m_ent[s][w].ctr);
      c2 = t ? ((c2 < 3) ? c2 + 1 : 3) : ((c2 > 0) ? c2 - 1 : 0);
      m_ent[s][w].ctr = counter_states'(2'(c2));
      m_now++; m_stamp[s][w] = m_now;
    end else if (t != c) begin
      v = -1;
      for (int i = NWAYS - 1; i >= 0; i--) if (!m_ent[s][i].valid) v = i;
      if (v < 0) begin
        v = 0;
        for (int i = 1; i < NWAYS; i++) if (m_stamp[s][i] < m_stamp[s][v]) v = i;
      end
      m_ent[s][v].valid = 1'b1;
      m_ent[s][v].tag = 4'(m_tagv(pc));
      m_ent[s][v].ctr = t ? weakly_taken : weakly_not_taken;
      m_now++; m_stamp[s][v] = m_now;
      if (m_allocs != 32'hFFFF_FFFF) m_allocs++;
    end
  endtask

  // One clock of stimulus; expectations for the resulting response are left in exp_*.
  task automatic cyc(input bit rv, input int rpc, input int rghr,
                     input bit uv, input int upc, input int ughr, input bit ut, input bit uc,
                     input bit fl);
    bit h; int w;
    rd_valid = rv; rd_pc = 10'(rpc); rd_ghr = 10'(rghr);
    upd_valid = uv; upd_pc = 10'(upc); upd_ghr = 10'(ughr);
    upd_taken = ut; upd_choice_taken = uc; flush = fl;
    if (rv) begin
      exp_valid = 1;
      if (fl) begin
        exp_hit = 0; exp_taken = 0; exp_way = 0;
      end else begin
        m_find(rpc, rghr, h, w);
        exp_hit = h; exp_way = h ? w : 0;
        exp_taken = h && m_ent[m_set(rpc, rghr)][w].ctr[1];
      end
      if (m_lookups != 32'hFFFF_FFFF) m_lookups++;
      if (exp_hit && m_hits != 32'hFFFF_FFFF) m_hits++;
    end else begin
      exp_valid = 0;
    end
    if (fl) m_clear();
    else if (uv) m_update(upc, ughr, ut, uc);
    @(posedge clk); #1;
    rd_valid = 0; upd_valid = 0; flush = 0;
  endtask

  task automatic lookup(input int pc, input int ghr);
    cyc(1, pc, ghr, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic train(input int pc, input int ghr, input bit t, input bit c);
    cyc(0, 0, 0, 1, pc, ghr, t, c, 0);
  endtask

  task automatic test_reset();
    reset = 1; m_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (rd_resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", rd_resp_valid); end
    n_cmp++; if (rd_hit !== 1'b0 || rd_taken !== 1'b0 || rd_way !== 1'b0) begin n_bad++; $display("FAIL reset_rd: got hit=%b taken=%b way=%b want 0/0/0", rd_hit, rd_taken, rd_way); end
    n_cmp++; if (stat_lookups !== 0 || stat_hits !== 0 || stat_allocs !== 0) begin n_bad++; $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0", stat_lookups, stat_hits, stat_allocs); end
    reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_first_miss();
    lookup(12'h024, 0);
    n_cmp++; if (rd_resp_valid !== 1'b1) begin n_bad++; $display("FAIL miss_resp_valid: got %b want 1", rd_resp_valid); end
    n_cmp++; if (rd_hit !== 1'b0 || rd_taken !== 1'b0) begin n_bad++; $display("FAIL miss_rd: got hit=%b taken=%b want 0/0", rd_hit, rd_taken); end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (rd_resp_valid !== 1'b0) begin n_bad++; $display("FAIL resp_valid_drop: got %b want 0", rd_resp_valid); end
  endtask

  task automatic test_alloc();
    train(12'h024, 0, 1, 0);
    lookup(12'h024, 0);
    n_cmp++; if (rd_hit !== 1'b1 || rd_way !== 1'b0 || rd_taken !== 1'b1) begin n_bad++; $display("FAIL alloc_hit: got hit=%b way=%b taken=%b want 1/0/1", rd_hit, rd_way, rd_taken); end
    n_cmp++; if (stat_allocs !== st(1)) begin n_bad++; $display("FAIL alloc_stat: got %0d want %0d", stat_allocs, st(1)); end
    n_cmp++; if (stat_lookups !== st(2) || stat_hits !== st(1)) begin n_bad++; $display("FAIL lookup_stats: got %0d/%0d want %0d/%0d", stat_lookups, stat_hits, st(2), st(1)); end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (rd_hit !== 1'b1 || rd_taken !== 1'b1 || rd_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_hold: got v=%b hit=%b taken=%b want 0/1/1", rd_resp_valid, rd_hit, rd_taken); end
  endtask

  task automatic test_train();
    train(12'h024, 0, 0, 0);
    lookup(12'h024, 0);
    n_cmp++; if (rd_hit !== 1'b1 || rd_taken !== 1'b0) begin n_bad++; $display("FAIL train_wnt: got hit=%b taken=%b want 1/0", rd_hit, rd_taken); end
    train(12'h024, 0, 0, 0);
    train(12'h024, 0, 0, 0);
    lookup(12'h024, 0);
    n_cmp++; if (rd_hit !== 1'b1 || rd_taken !== 1'b0) begin n_bad++; $display("FAIL train_snt_sat: got hit=%b taken=%b want 1/0", rd_hit, rd_taken); end
    train(12'h024, 0, 1, 0);
    lookup(12'h024, 0);
    n_cmp++; if (rd_taken !== 1'b0) begin n_bad++; $display("FAIL train_snt_to_wnt: got taken=%b want 0", rd_taken); end
    train(12'h024, 0, 1, 0);
    lookup(12'h024, 0);
    n_cmp++; if (rd_taken !== 1'b1) begin n_bad++; $display("FAIL train_wnt_to_wt: got taken=%b want 1", rd_taken); end
  endtask

  task automatic test_lru();
    // A/B/C share set 5 with tags 1/2/3.
    train(12'h004, 4, 1, 0);
    train(12'h008, 7, 1, 0);
    train(12'h004, 4, 1, 0);
    train(12'h00C, 6, 0, 1);
    lookup(12'h004, 4);
    n_cmp++; if (rd_hit !== 1'b1 || rd_way !== 1'b0) begin n_bad++; $display("FAIL lru_a: got hit=%b way=%b want 1/0", rd_hit, rd_way); end
    lookup(12'h00C, 6);
    n_cmp++; if (rd_hit !== 1'b1 || rd_way !== 1'b1 || rd_taken !== 1'b0) begin n_bad++; $display("FAIL lru_c: got hit=%b way=%b taken=%b want 1/1/0", rd_hit, rd_way, rd_taken); end
    lookup(12'h008, 7);
    n_cmp++; if (rd_hit !== 1'b0) begin n_bad++; $display("FAIL lru_b_evicted: got hit=%b want 0", rd_hit); end
  endtask

  task automatic test_agree();
    train(12'h030, 0, 1, 1);
    lookup(12'h030, 0);
    n_cmp++; if (rd_hit !== 1'b0) begin n_bad++; $display("FAIL agree_no_alloc: got hit=%b want 0", rd_hit); end
    n_cmp++; if (stat_allocs !== st(m_allocs)) begin n_bad++; $display("FAIL agree_stat: got %0d want %0d", stat_allocs, st(m_allocs)); end
  endtask

  task automatic test_same_cycle();
    cyc(1, 12'h040, 0, 1, 12'h040, 0, 1, 0, 0);
    n_cmp++; if (rd_resp_valid !== 1'b1 || rd_hit !== 1'b0) begin n_bad++; $display("FAIL rbw_miss: got v=%b hit=%b want 1/0", rd_resp_valid, rd_hit); end
    lookup(12'h040, 0);
    n_cmp++; if (rd_hit !== 1'b1 || rd_taken !== 1'b1) begin n_bad++; $display("FAIL rbw_next_hit: got hit=%b taken=%b want 1/1", rd_hit, rd_taken); end
  endtask

  task automatic test_flush();
    cyc(1, 12'h024, 0, 1, 12'h050, 0, 1, 0, 1);
    n_cmp++; if (rd_resp_valid !== 1'b1 || rd_hit !== 1'b0 || rd_taken !== 1'b0) begin n_bad++; $display("FAIL flush_resp: got v=%b hit=%b taken=%b want 1/0/0", rd_resp_valid, rd_hit, rd_taken); end
    lookup(12'h050, 0);
    n_cmp++; if (rd_hit !== 1'b0) begin n_bad++; $display("FAIL flush_drop_upd: got hit=%b want 0", rd_hit); end
    lookup(12'h004, 4);
    n_cmp++; if (rd_hit !== 1'b0) begin n_bad++; $display("FAIL flush_invalidate: got hit=%b want 0", rd_hit); end
    n_cmp++; if (stat_allocs !== st(m_allocs) || stat_lookups !== st(m_lookups)) begin n_bad++; $display("FAIL flush_keeps_stats: got %0d/%0d want %0d/%0d", stat_allocs, stat_lookups, st(m_allocs), st(m_lookups)); end
  endtask

  task automatic test_reset_mid();
    train(12'h060, 0, 1, 0);
    lookup(12'h060, 0);
    n_cmp++; if (rd_resp_valid !== 1'b1 || rd_hit !== 1'b1) begin n_bad++; $display("FAIL pre_reset_hit: got v=%b hit=%b want 1/1", rd_resp_valid, rd_hit); end
    #2 reset = 1;
    #1;
    n_cmp++; if (rd_resp_valid !== 1'b0 || rd_hit !== 1'b0 || rd_taken !== 1'b0 || stat_lookups !== 0) begin n_bad++; $display("FAIL async_reset: got v=%b hit=%b taken=%b lk=%0d want 0/0/0/0", rd_resp_valid, rd_hit, rd_taken, stat_lookups); end
    m_reset();
    @(posedge clk); #1;
    reset = 0;
    lookup(12'h060, 0);
    n_cmp++; if (rd_hit !== 1'b0) begin n_bad++; $display("FAIL reset_clears_entries: got hit=%b want 0", rd_hit); end
  endtask

  task automatic test_random();
    int rpc, upc;
    for (int i = 0; i < 800; i++) begin
      rpc = int'($urandom_range(0, 7)) << 2 | int'($urandom_range(0, 1)) << 6;
      upc = int'($urandom_range(0, 7)) << 2 | int'($urandom_range(0, 1)) << 6;
      cyc($urandom_range(0, 3) != 0, rpc, int'($urandom_range(0, 3)),
          $urandom_range(0, 2) != 0, upc, int'($urandom_range(0, 3)),
          1'($urandom), 1'($urandom), $urandom_range(0, 99) == 0);
      n_cmp++;
      if (rd_resp_valid !== exp_valid || rd_hit !== exp_hit || rd_taken !== exp_taken || rd_way !== 1'(exp_way)) begin
        n_bad++;
        $display("FAIL rand_resp[%0d]: got v=%b hit=%b taken=%b way=%0d want %b/%b/%b/%0d", i,
                 rd_resp_valid, rd_hit, rd_taken, rd_way, exp_valid, exp_hit, exp_taken, exp_way);
      end
      n_cmp++;
      if (stat_lookups !== st(m_lookups) || stat_hits !== st(m_hits) || stat_allocs !== st(m_allocs)) begin
        n_bad++;
        $display("FAIL rand_stats[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", i, stat_lookups, stat_hits,
                 stat_allocs, st(m_lookups), st(m_hits), st(m_allocs));
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_miss();
    test_alloc();
    test_train();
    test_lru();
    test_agree();
    test_same_cycle();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
